data_mem_responder: RTL and testbench

//   Memory-side responder for the CPU data port. Takes byte address, 4-bit lane select (sel) and

---
 rtl/data_mem_responder_pkg.sv | 22 ++
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/data_mem_responder_bank.sv | 43 ++++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
//   Shared definitions for the CPU data-port memory responder:
//     - FSM state encodings (2 bits)
//     - lane-select shorthands for a read and for a full-word write
//     - a helper that classifies a lane select as a write
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] SEL_READ = 4'b0000;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Any non-zero lane select is a (possibly partial) write.
  function automatic logic is_write(input logic [3:0] sel);
    return sel != SEL_READ;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between the load/store unit (master) and the
//   data memory responder (slave).
//     req    master->slave  request strobe
//     sel    master->slave  byte-lane write enables, 0000 = read
//     addr   master->slave  byte address
//     wdata  master->slave  lane-replicated write data
//     rdata  slave->master  response word, valid with ack
//     ack    slave->master  one-cycle completion pulse
//     busy   slave->master  access in flight (accept through ack)
//     err    slave->master  address error, valid with ack
interface data_mem_responder_if;
  logic        req;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req, sel, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, sel, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/data_mem_responder_bank.sv
// dmem_bank
//   Word-organised RAM built from four byte-wide synchronous arrays that
//   share one word index. Each lane has its own write enable. The read
//   register updates only when en=1 and returns the new byte on lanes being
//   written in the same cycle (write-first); unwritten lanes return the
//   stored byte. Array contents are not reset; the read register is.
//   Ports:
//     clk     clock, rising edge
//     resetn  asynchronous active-low reset (read register only)
//     en      access strobe for this cycle
//     we      per-lane write enables (qualified by en)
//     idx     word index
//     wdata   write data, lane i = wdata[8i+7:8i]
//     q       registered read word, held between accesses
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] q_lane;

    always_ff @(posedge clk) begin
      if (en && we[i]) mem[idx] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  q_lane <= '0;
      else if (en)  q_lane <= we[i] ? wdata[8*i +: 8] : mem[idx];
    end

    assign q[8*i +: 8] = q_lane;
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one request in
//   IDLE, waits WAIT_CYCLES cycles, performs the word access on the edge
//   into RESP and pulses ack on the following cycle with the full 32-bit
//   word (merged new word for writes, stored word for reads).
//   Optional feature macro: DMEM_ADDR_CHECK_EN -- when defined, an address
//   with any bit set above the RAM range raises err with ack, suppresses the
//   write and returns rdata=0. When undefined, upper bits alias and err=0.
//   Parameters:
//     ADDR_W       word-address width, RAM depth 2**ADDR_W words
//     WAIT_CYCLES  extra wait states between accept and ack (0..15)
//   Ports:
//     clk     clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     slave side of data_mem_responder_if
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  data_mem_responder_if.slave  bus
);

  dmem_state_e       state, state_n;
  logic [3:0]        cnt, cnt_n;

  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic              aerr_q;

  logic              ack_q, busy_q, err_q;

  logic              acc_go;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [3:0]        bank_we;
  logic [31:0]       bank_q;

  logic              live_aerr;
`ifdef DMEM_ADDR_CHECK_EN
  logic              unused_lo;
  assign live_aerr = bus.addr[31:ADDR_W+2] != '0;
  assign unused_lo = ^bus.addr[1:0];
`else
  logic              unused_addr;
  assign live_aerr   = 1'b0;
  assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

  // Next state and the access strobe for the edge into RESP. With no wait
  // states the access happens on the accepting edge, so it uses the live
  // request fields instead of the latched copies.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_go    = 1'b0;
    acc_idx   = idx_q;
    acc_sel   = sel_q;
    acc_wdata = wdata_q;
    acc_err   = aerr_q;
    unique case (state)
      DMEM_IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_n   = DMEM_RESP;
            acc_go    = 1'b1;
            acc_idx   = bus.addr[ADDR_W+1:2];
            acc_sel   = bus.sel;
            acc_wdata = bus.wdata;
            acc_err   = live_aerr;
          end else begin
            state_n = DMEM_WAIT;
            cnt_n   = 4'(WAIT_CYCLES);
          end
        end
      end
      DMEM_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = DMEM_RESP;
          acc_go  = 1'b1;
        end
      end
      DMEM_RESP: state_n = DMEM_IDLE;
      default:   state_n = DMEM_IDLE;
    endcase
  end

  assign bank_we = (is_write(acc_sel) && !acc_err) ? acc_sel : SEL_READ;

  // Control registers. ack follows RESP by one cycle so that it lands
  // WAIT_CYCLES+1 cycles after the accept; busy covers that ack cycle too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DMEM_IDLE;
      cnt    <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ack_q  <= state == DMEM_RESP;
      busy_q <= (state_n != DMEM_IDLE) || (state == DMEM_RESP);
      if (acc_go) err_q <= acc_err;
    end
  end

  // Request latch, loaded only on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == DMEM_IDLE && bus.req) begin
      idx_q   <= bus.addr[ADDR_W+1:2];
      sel_q   <= bus.sel;
      wdata_q <= bus.wdata;
      aerr_q  <= live_aerr;
    end
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk    (clk),
    .resetn (resetn),
    .en     (acc_go),
    .we     (bank_we),
    .idx    (acc_idx),
    .wdata  (acc_wdata),
    .q      (bank_q)
  );

  // err_q holds until the next access, so masking keeps rdata at 0 after a
  // rejected access just as the bank word is held after a good one.
  assign bus.rdata = err_q ? 32'h0 : bank_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = ack_q & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. dut0 runs with WAIT_CYCLES=2,
//   dut1 with WAIT_CYCLES=0; both use ADDR_W=10 and share clock and reset.
//   Expected values are hand-computed constants. The address-error case
//   picks its expectation from DMEM_ADDR_CHECK_EN.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  data_mem_responder_if m0_if();
  data_mem_responder_if m1_if();

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .resetn(resetn), .bus(m0_if.slave));

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .resetn(resetn), .bus(m1_if.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on dut0; lat counts edges from the accepting edge to the
  // edge that raises ack (-1 if ack never came).
  task automatic access(input logic [3:0] s, input logic [31:0] a, input logic [31:0] w,
                        output logic [31:0] rd, output logic er, output int lat);
    rd = 32'hx; er = 1'bx; lat = -1;
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.sel = s; m0_if.addr = a; m0_if.wdata = w;
    @(posedge clk);
    @(negedge clk);
    m0_if.req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (m0_if.ack) begin
        lat = k; rd = m0_if.rdata; er = m0_if.err;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          acks;
  logic [31:0] d1 [4];

  initial begin
    m0_if.req = 1'b0; m0_if.sel = '0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.sel = '0; m1_if.addr = '0; m1_if.wdata = '0;
    d1[0] = 32'h0102_0304; d1[1] = 32'hA5A5_5A5A;
    d1[2] = 32'hFFFF_0000; d1[3] = 32'h1357_9BDF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdata", m0_if.rdata, 32'h0);
    chk("rst_ack",   m0_if.ack,   1'b0);
    chk("rst_busy",  m0_if.busy,  1'b0);
    chk("rst_err",   m0_if.err,   1'b0);
    resetn = 1'b1;

    // Word write then read back, ack at accept+3
    access(SEL_WORD, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    chk("wr_lat",   lat, 3);
    chk("wr_rdata", rd,  32'hDEAD_BEEF);
    chk("wr_err",   er,  1'b0);
    access(SEL_READ, 32'h0000_0010, 32'h0, rd, er, lat);
    chk("rd_lat",   lat, 3);
    chk("rd_rdata", rd,  32'hDEAD_BEEF);

    // Byte and halfword lanes
    access(4'b0100, 32'h0000_0010, 32'h5A5A_5A5A, rd, er, lat);
    chk("byte2", rd, 32'hDE5A_BEEF);
    access(4'b0011, 32'h0000_0012, 32'h1234_1234, rd, er, lat);
    chk("half0", rd, 32'hDE5A_1234);
    access(SEL_READ, 32'h0000_0011, 32'h0, rd, er, lat);
    chk("lanes_rb", rd, 32'hDE5A_1234);

    // Reset in WAIT drops the access
    access(SEL_WORD, 32'h0000_0040, 32'h1111_1111, rd, er, lat);
    chk("pre_rst_wr", rd, 32'h1111_1111);
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.sel = SEL_WORD; m0_if.addr = 32'h40; m0_if.wdata = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    m0_if.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", m0_if.busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", m0_if.busy, 1'b0);
    chk("mid_rst_ack",  m0_if.ack,  1'b0);
    @(negedge clk);
    resetn = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (m0_if.ack) acks++;
    end
    chk("mid_rst_noack", acks, 0);
    access(SEL_READ, 32'h0000_0040, 32'h0, rd, er, lat);
    chk("mid_rst_nowr", rd, 32'h1111_1111);

    // Requests during WAIT and RESP are ignored
    access(SEL_WORD, 32'h0000_0030, 32'hAAAA_AAAA, rd, er, lat);
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.sel = SEL_READ; m0_if.addr = 32'h30; m0_if.wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    m0_if.sel = SEL_WORD; m0_if.wdata = 32'hBBBB_BBBB;
    acks = 0; lat = -1; rd = 32'hx;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (m0_if.ack) begin
        acks++;
        if (lat < 0) begin lat = k; rd = m0_if.rdata; end
      end
      if (k == 3) m0_if.req = 1'b0;
    end
    chk("busy_acks",  acks, 1);
    chk("busy_lat",   lat,  3);
    chk("busy_rdata", rd,   32'hAAAA_AAAA);
    access(SEL_READ, 32'h0000_0030, 32'h0, rd, er, lat);
    chk("busy_ram", rd, 32'hAAAA_AAAA);

    // WAIT_CYCLES=0: back-to-back requests every 2 cycles
    @(negedge clk);
    m1_if.req = 1'b1; m1_if.sel = SEL_WORD; m1_if.addr = 32'h20; m1_if.wdata = d1[0];
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_ack%0d", k), m1_if.ack, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("w0_busy%0d", k), m1_if.busy, 1'b1);
      if (k % 2 == 1) chk($sformatf("w0_rdata%0d", k), m1_if.rdata, d1[k / 2]);
      @(negedge clk);
      if (k % 2 == 1 && k < 7) m1_if.wdata = d1[(k + 1) / 2];
      if (k == 6) m1_if.req = 1'b0;
    end

    // Out-of-range address
    access(SEL_WORD, 32'h0000_1010, 32'hCAFE_F00D, rd, er, lat);
    chk("oor_lat", lat, 3);
`ifdef DMEM_ADDR_CHECK_EN
    chk("oor_err",   er, 1'b1);
    chk("oor_rdata", rd, 32'h0);
    access(SEL_READ, 32'h0000_0010, 32'h0, rd, er, lat);
    chk("oor_kept",  rd, 32'hDE5A_1234);
    chk("oor_rderr", er, 1'b0);
`else
    chk("oor_err",   er, 1'b0);
    chk("oor_rdata", rd, 32'hCAFE_F00D);
    access(SEL_READ, 32'h0000_0010, 32'h0, rd, er, lat);
    chk("oor_alias", rd, 32'hCAFE_F00D);
    chk("oor_rderr", er, 1'b0);
`endif

    // rdata holds after ack
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rdata", m0_if.rdata, rd);
    chk("hold_ack",   m0_if.ack,   1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
